// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stage-register sequencer.
// The state encoding is visible on the top-level state port.
package pipe_ctrl_pkg;

   localparam int STATE_W    = 2;
   localparam int DEF_REG_AW = 4;

   typedef enum logic [STATE_W-1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory status from the pipeline and the stage-register controls back to it.
// The slave side is the sequencer; the master side is the pipeline datapath.
interface pipeline_ctrl_if #(
   parameter int REG_AW = pipe_ctrl_pkg::DEF_REG_AW,
   parameter int CNT_W  = 16
) ();

   logic [REG_AW-1:0]                 id_src1;
   logic [REG_AW-1:0]                 id_src2;
   logic                              id_two_src;
   logic                              id_valid;
   logic [REG_AW-1:0]                 exe_dest;
   logic                              exe_wb_en;
   logic                              exe_mem_r_en;
   logic                              exe_branch;
   logic [REG_AW-1:0]                 mem_dest;
   logic                              mem_wb_en;
   logic                              mem_req;
   logic                              mem_ready;

   logic                              freeze_front;
   logic                              freeze_back;
   logic                              flush_ifid;
   logic                              bubble_idex;
   logic                              fault;
   logic [pipe_ctrl_pkg::STATE_W-1:0] state;
   logic [CNT_W-1:0]                  stall_cnt;
   logic [CNT_W-1:0]                  flush_cnt;

   modport master (
      output id_src1, id_src2, id_two_src, id_valid,
      output exe_dest, exe_wb_en, exe_mem_r_en, exe_branch,
      output mem_dest, mem_wb_en, mem_req, mem_ready,
      input  freeze_front, freeze_back, flush_ifid, bubble_idex,
      input  fault, state, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_src1, id_src2, id_two_src, id_valid,
      input  exe_dest, exe_wb_en, exe_mem_r_en, exe_branch,
      input  mem_dest, mem_wb_en, mem_req, mem_ready,
      output freeze_front, freeze_back, flush_ifid, bubble_idex,
      output fault, state, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW hazard check of the ID sources against EXE/MEM destinations.
// With forwarding only a load in EXE stalls; without it any pending write-back does.
module hazard_detect #(
   parameter int REG_AW = pipe_ctrl_pkg::DEF_REG_AW,
   parameter bit FWD_EN = 1'b1
) (
   input  logic [REG_AW-1:0] src1,
   input  logic [REG_AW-1:0] src2,
   input  logic              two_src,
   input  logic              valid,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic              exe_wb_en,
   input  logic              exe_mem_r_en,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_wb_en,
   output logic              hazard
);

   logic exe_hit;
   logic mem_hit;
   logic load_use;
   logic any_use;

   assign exe_hit  = (exe_dest == src1) | (two_src & (exe_dest == src2));
   assign mem_hit  = (mem_dest == src1) | (two_src & (mem_dest == src2));

   assign load_use = valid & exe_wb_en & exe_mem_r_en & exe_hit;
   assign any_use  = valid & ((exe_wb_en & exe_hit) | (mem_wb_en & mem_hit));

   assign hazard   = FWD_EN ? load_use : any_use;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage-register sequencer: freeze/flush/bubble controls from a RUN/MEM_WAIT/FAULT FSM,
// plus saturating stall/flush event counters and a sticky memory-timeout fault.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW      = DEF_REG_AW,
   parameter bit FWD_EN      = 1'b1,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic          clk,
   input  logic          rst,
   pipeline_ctrl_if.slave bus
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_t            state_q, state_nxt;
   logic [WAIT_W-1:0] wait_q, wait_nxt;
   logic              fault_q, fault_nxt;
   logic [CNT_W-1:0]  stall_q, flush_q;

   logic hazard;
   logic mem_stall;
   logic run_rules;
   logic front_c, back_c, flush_c, bubble_c;
   logic stall_inc, flush_inc;

   hazard_detect #(
      .REG_AW (REG_AW),
      .FWD_EN (FWD_EN)
   ) u_hazard (
      .src1         (bus.id_src1),
      .src2         (bus.id_src2),
      .two_src      (bus.id_two_src),
      .valid        (bus.id_valid),
      .exe_dest     (bus.exe_dest),
      .exe_wb_en    (bus.exe_wb_en),
      .exe_mem_r_en (bus.exe_mem_r_en),
      .mem_dest     (bus.mem_dest),
      .mem_wb_en    (bus.mem_wb_en),
      .hazard       (hazard)
   );

   assign mem_stall = bus.mem_req & ~bus.mem_ready;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state_q;
      wait_nxt  = wait_q;
      fault_nxt = fault_q;
      run_rules = 1'b0;
      front_c   = 1'b0;
      back_c    = 1'b0;
      flush_c   = 1'b0;
      bubble_c  = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;

      unique case (state_q)
         RUN: begin
            if (mem_stall) begin
               front_c   = 1'b1;
               back_c    = 1'b1;
               state_nxt = MEM_WAIT;
               wait_nxt  = WAIT_W'(1);
            end else begin
               run_rules = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!bus.mem_ready) begin
               front_c = 1'b1;
               back_c  = 1'b1;
               if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                  state_nxt = FAULT;
                  fault_nxt = 1'b1;
               end else begin
                  wait_nxt = wait_q + WAIT_W'(1);
               end
            end else begin
               // Release cycle: a branch held in EXE during the wait is flushed right now.
               run_rules = 1'b1;
               state_nxt = RUN;
               wait_nxt  = '0;
            end
         end
         FAULT: begin
            front_c = 1'b1;
            back_c  = 1'b1;
         end
         default: begin
            front_c   = 1'b1;
            back_c    = 1'b1;
            state_nxt = FAULT;
            fault_nxt = 1'b1;
         end
      endcase

      if (run_rules) begin
         if (bus.exe_branch) begin
            flush_c   = 1'b1;
            bubble_c  = 1'b1;
            flush_inc = 1'b1;
         end else if (hazard) begin
            front_c   = 1'b1;
            bubble_c  = 1'b1;
            stall_inc = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         wait_q  <= wait_nxt;
         fault_q <= fault_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
         if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   // Controls are Mealy, so they are gated to keep the pipeline quiet while reset is held.
   assign bus.freeze_front = rst & front_c;
   assign bus.freeze_back  = rst & back_c;
   assign bus.flush_ifid   = rst & flush_c;
   assign bus.bubble_idex  = rst & bubble_c;
   assign bus.fault        = fault_q;
   assign bus.state        = state_q;
   assign bus.stall_cnt    = stall_q;
   assign bus.flush_cnt    = flush_q;

endmodule
